// File: rtl/spi_frame_fsm.sv
// SPI slave frame sequencer: header capture, address latch, read/write data phases,
// optional burst with address auto-increment, and a one-cycle pulse on aborted frames.
module spi_frame_fsm #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter bit          BURST_EN = 1'b0
) (
  input  logic sclk,
  input  logic reset,
  input  logic chip_sel,
  input  logic shift_reg_out,
  output logic miso_buff,
  output logic dm_we,
  output logic addr_we,
  output logic sr_we,
  output logic addr_inc,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned H      = ADDR_W + 1;
  localparam int unsigned MaxLen = (H > DATA_W) ? H : DATA_W;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam logic [CntW-1:0] HdrLast  = CntW'(H - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StGet,
    StGot,
    StReadLoad,
    StReadShift,
    StWrite,
    StWriteCommit,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    miso_buff   = 1'b0;
    dm_we       = 1'b0;
    addr_we     = 1'b0;
    sr_we       = 1'b0;
    addr_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StGet;
        cnt_d   = CntOne;
      end
      StGet: begin
        if (cnt_q == HdrLast) begin
          state_d = StGot;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGot: begin
        addr_we = 1'b1;
        cnt_d   = '0;
        state_d = shift_reg_out ? StReadLoad : StWrite;
      end
      StReadLoad: begin
        sr_we   = 1'b1;
        cnt_d   = '0;
        state_d = StReadShift;
      end
      StReadShift: begin
        miso_buff = 1'b1;
        if (cnt_q == DataLast) begin
          // Bump the address a cycle early so the next READ_LOAD sees fresh memory data.
          addr_inc = BURST_EN && !chip_sel;
          cnt_d    = '0;
          state_d  = BURST_EN ? StReadLoad : StDone;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWrite: begin
        if (cnt_q == DataLast) begin
          cnt_d   = '0;
          state_d = StWriteCommit;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWriteCommit: begin
        dm_we    = 1'b1;
        addr_inc = BURST_EN;
        cnt_d    = '0;
        state_d  = BURST_EN ? StWrite : StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (chip_sel) begin
      state_d = StIdle;
      cnt_d   = '0;
      // cnt==0 in a data phase is a word boundary, so deselecting there is a clean stop.
      unique case (state_q)
        StGet, StGot, StReadLoad: frame_err_d = 1'b1;
        StReadShift, StWrite:     frame_err_d = (cnt_q != '0);
        default:                  frame_err_d = 1'b0;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_frame_fsm.sv
// Scoreboard bench for spi_frame_fsm: expected output vectors derived from frame timing
// are queued as stimulus is driven and compared on the falling edge.
module tb_spi_frame_fsm;

  logic       sclk = 1'b0;
  logic       reset;
  logic       shift_reg_out;
  logic [2:0] cs;
  // {busy, frame_err, addr_inc, sr_we, dm_we, addr_we, miso_buff}
  logic [6:0] o0, o1, o2;

  always #5 sclk = ~sclk;

  spi_frame_fsm u_dut0 (
    .sclk(sclk), .reset(reset), .chip_sel(cs[0]), .shift_reg_out(shift_reg_out),
    .miso_buff(o0[0]), .dm_we(o0[2]), .addr_we(o0[1]), .sr_we(o0[3]),
    .addr_inc(o0[4]), .busy(o0[6]), .frame_err(o0[5])
  );

  spi_frame_fsm #(.BURST_EN(1'b1)) u_dut1 (
    .sclk(sclk), .reset(reset), .chip_sel(cs[1]), .shift_reg_out(shift_reg_out),
    .miso_buff(o1[0]), .dm_we(o1[2]), .addr_we(o1[1]), .sr_we(o1[3]),
    .addr_inc(o1[4]), .busy(o1[6]), .frame_err(o1[5])
  );

  spi_frame_fsm #(.ADDR_W(4), .DATA_W(16)) u_dut2 (
    .sclk(sclk), .reset(reset), .chip_sel(cs[2]), .shift_reg_out(shift_reg_out),
    .miso_buff(o2[0]), .dm_we(o2[2]), .addr_we(o2[1]), .sr_we(o2[3]),
    .addr_inc(o2[4]), .busy(o2[6]), .frame_err(o2[5])
  );

  typedef struct {
    int          scen;
    int          cyc;
    logic [20:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge sclk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check_eq($sformatf("s%0d_c%0d", mon_e.scen, mon_e.cyc), {o2, o1, o0}, mon_e.exp);
    end
  end

  // Outputs in cycle c of an uninterrupted frame (cycle 0 = edge that leaves IDLE).
  function automatic logic [6:0] frame_out(int c, int h, int dw, bit burst, bit rd, int a);
    logic [6:0] v;
    int k, j;
    v = 7'b100_0000;
    if (c < h) return v;
    if (c == h) begin
      v[1] = 1'b1;
      return v;
    end
    k = c - h - 1;
    if (!burst && k >= dw + 1) return v;
    j = k % (dw + 1);
    if (rd) begin
      if (j == 0) v[3] = 1'b1;
      else begin
        v[0] = 1'b1;
        if (burst && j == dw && c < a) v[4] = 1'b1;
      end
    end else if (j == dw) begin
      v[2] = 1'b1;
      v[4] = burst;
    end
    return v;
  endfunction

  // Whether deselecting while in cycle a of the frame counts as an abort.
  function automatic bit abort_err(int a, int h, int dw, bit burst, bit rd);
    int k, j;
    if (a <= 0) return 1'b0;
    if (a <= h) return 1'b1;
    k = a - h - 1;
    if (!burst && k >= dw + 1) return 1'b0;
    j = k % (dw + 1);
    if (rd) return (j == 0) || (j - 1 != 0);
    if (j == dw) return 1'b0;
    return j != 0;
  endfunction

  task automatic run_scen(input int scen, input int d, input int h, input int dw,
                          input bit burst, input bit rd, input int a, input bit rst);
    logic [6:0]  v;
    logic [20:0] e;
    for (int c = -2; c <= a + 3; c++) begin
      @(posedge sclk);
      #1;
      cs    = 3'b111;
      reset = 1'b0;
      if (c >= 0 && (c < a || (rst && c == a))) cs[d] = 1'b0;
      if (rst && c == a) reset = 1'b1;
      shift_reg_out = (c == h) ? rd : 1'($urandom_range(0, 1));
      if (c <= 0)          v = '0;
      else if (c <= a)     v = frame_out(c, h, dw, burst, rd, a);
      else if (c == a + 1) v = {1'b0, (!rst && abort_err(a, h, dw, burst, rd)), 5'b0};
      else                 v = '0;
      e = '0;
      e[d*7 +: 7] = v;
      sb_q.push_back('{scen, c, e});
    end
  endtask

  initial begin
    reset         = 1'b1;
    cs            = 3'b111;
    shift_reg_out = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    reset = 1'b0;
    sb_q.push_back('{0, 0, 21'd0});

    run_scen(1, 0, 8, 8, 1'b0, 1'b0, 20, 1'b0);   // plain write
    run_scen(2, 0, 8, 8, 1'b0, 1'b1, 20, 1'b0);   // plain read
    run_scen(3, 0, 8, 8, 1'b0, 1'b0, 14, 1'b0);   // abort in WRITE, cnt=5
    run_scen(4, 0, 8, 8, 1'b0, 1'b0, 17, 1'b0);   // deselect during commit
    run_scen(5, 0, 8, 8, 1'b0, 1'b0, 4, 1'b1);    // reset mid-GET
    run_scen(6, 1, 8, 8, 1'b1, 1'b1, 36, 1'b0);   // burst read, abort at READ_LOAD
    run_scen(7, 1, 8, 8, 1'b1, 1'b1, 37, 1'b0);   // burst read, stop at READ_SHIFT cnt=0
    run_scen(8, 1, 8, 8, 1'b1, 1'b0, 27, 1'b0);   // burst write, stop at WRITE cnt=0
    run_scen(9, 2, 5, 16, 1'b0, 1'b0, 24, 1'b0);  // narrow address, wide data write
    run_scen(10, 2, 5, 16, 1'b0, 1'b1, 3, 1'b0);  // abort in GET

    @(posedge sclk);
    @(negedge sclk);
    #1;
    check_eq("sb_drain", 21'(sb_q.size()), 21'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
